mux_2to1: RTL and testbench

MUX_2TO1 -- requirements
Module: mux_2to1

---
 rtl/mux_2to1.sv | 49 ++++
 tb/tb_mux_2to1.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - registered 2:1 mux with combinational tap and select-switch counter
module mux_2to1 #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in0,
    input  logic [N-1:0]     in1,
    input  logic             sel,
    input  logic             in_valid,
    output logic [N-1:0]     out,
    output logic [N-1:0]     out_comb,
    output logic             out_valid,
    output logic             sel_q,
    output logic [CNT_W-1:0] sw_cnt
);

    // Set by the first capture after reset; a switch needs a previous sel to compare against.
    logic seen;

    // Direct select path; no clock involvement.
    always_comb begin
        out_comb = sel ? in1 : in0;
    end

    // Capture on valid input, hold otherwise; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            sel_q     <= 1'b0;
            sw_cnt    <= '0;
            seen      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out   <= out_comb;
                sel_q <= sel;
                seen  <= 1'b1;
                // Counter wraps naturally at its width.
                if (seen && (sel != sel_q)) begin
                    sw_cnt <= sw_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_2to1.sv
// tb/tb_mux_2to1.sv - directed scoreboard bench for mux_2to1
module tb_mux_2to1;

    typedef struct packed {
        logic [3:0] d;
        logic       s;
        logic [7:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in0;
    logic [3:0] in1;
    logic       sel;
    logic       in_valid;

    logic [3:0] out_a, comb_a;
    logic       valid_a, selq_a;
    logic [7:0] cnt_a;
    logic [3:0] out_b, comb_b;
    logic       valid_b, selq_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic       m_seen, m_sel, m_valid;
    logic [3:0] m_out;
    logic [7:0] m_cnt;

    always #5 clk = ~clk;

    mux_2to1 #(.N(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .sel(sel),
        .in_valid(in_valid), .out(out_a), .out_comb(comb_a),
        .out_valid(valid_a), .sel_q(selq_a), .sw_cnt(cnt_a)
    );

    mux_2to1 #(.N(4), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .sel(sel),
        .in_valid(in_valid), .out(out_b), .out_comb(comb_b),
        .out_valid(valid_b), .sel_q(selq_b), .sw_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational path, then registered state after the edge.
    task automatic step(input logic r, input logic v, input logic s,
                        input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        logic [3:0] ec;
        @(negedge clk);
        rst_n = r; in_valid = v; sel = s; in0 = a; in1 = b;
        ec = s ? b : a;
        #1;
        chk("out_comb", 64'(comb_a), 64'(ec));
        chk("out_comb_w2", 64'(comb_b), 64'(ec));
        if (!r) begin
            sb.delete();
            m_seen = 1'b0; m_sel = 1'b0; m_out = '0; m_cnt = '0; m_valid = 1'b0;
        end else if (v) begin
            if (m_seen && (s != m_sel)) m_cnt = m_cnt + 8'd1;
            m_seen = 1'b1; m_sel = s; m_out = ec; m_valid = 1'b1;
            e.d = ec; e.s = s; e.c = m_cnt;
            sb.push_back(e);
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(valid_a), 64'(m_valid));
        chk("out_valid_w2", 64'(valid_b), 64'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'(0), 64'(1));
            end else begin
                e = sb.pop_front();
                chk("out", 64'(out_a), 64'(e.d));
                chk("sel_q", 64'(selq_a), 64'(e.s));
                chk("sw_cnt", 64'(cnt_a), 64'(e.c));
                chk("out_w2", 64'(out_b), 64'(e.d));
                chk("sw_cnt_w2", 64'(cnt_b), 64'(e.c[1:0]));
            end
        end else begin
            chk("out_hold", 64'(out_a), 64'(m_out));
            chk("sel_q_hold", 64'(selq_a), 64'(m_sel));
            chk("sw_cnt_hold", 64'(cnt_a), 64'(m_cnt));
            chk("sw_cnt_hold_w2", 64'(cnt_b), 64'(m_cnt[1:0]));
        end
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic       rs;
        rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in0 = '0; in1 = '0;
        m_seen = 1'b0; m_sel = 1'b0; m_out = '0; m_cnt = '0; m_valid = 1'b0;

        // Reset with in_valid high: inputs must be ignored.
        step(1'b0, 1'b1, 1'b1, 4'h7, 4'h9);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("rst_out", 64'(out_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_selq", 64'(selq_a), 64'd0);
        chk("rst_cnt", 64'(cnt_a), 64'd0);

        // First capture: zeros, no switch counted.
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("first_cnt", 64'(cnt_a), 64'd0);

        // Data changes with sel stable.
        step(1'b1, 1'b1, 1'b0, 4'd5, 4'd10);
        chk("d5_out", 64'(out_a), 64'd5);
        step(1'b1, 1'b1, 1'b0, 4'd6, 4'd13);
        chk("d6_out", 64'(out_a), 64'd6);
        chk("d6_cnt", 64'(cnt_a), 64'd0);

        // sel 0->1 with new data on the same edge.
        step(1'b1, 1'b1, 1'b1, 4'd6, 4'd13);
        chk("s1_out", 64'(out_a), 64'd13);
        step(1'b1, 1'b1, 1'b1, 4'd14, 4'd9);
        step(1'b1, 1'b1, 1'b1, 4'd8, 4'd11);
        chk("s1_out_last", 64'(out_a), 64'd11);
        chk("s1_selq", 64'(selq_a), 64'd1);
        chk("s1_cnt", 64'(cnt_a), 64'd1);

        // sel 1->0.
        step(1'b1, 1'b1, 1'b0, 4'd8, 4'd11);
        chk("s0_out", 64'(out_a), 64'd8);
        chk("s0_cnt", 64'(cnt_a), 64'd2);

        // Idle cycles with toggling inputs: registered outputs hold.
        for (int i = 0; i < 3; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            step(1'b1, 1'b0, rs, ra, rb);
        end
        chk("idle_out", 64'(out_a), 64'd8);
        chk("idle_selq", 64'(selq_a), 64'd0);

        // Alternating captures: 2-bit counter wraps 3->0.
        for (int i = 0; i < 5; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            step(1'b1, 1'b1, ~1'(i), ra, rb);
            if (i == 1) chk("wrap_w2", 64'(cnt_b), 64'd0);
        end
        chk("alt_cnt", 64'(cnt_a), 64'd7);
        chk("alt_cnt_w2", 64'(cnt_b), 64'd3);

        // Reset mid-stream with a valid capture pending.
        step(1'b0, 1'b1, 1'b1, 4'd3, 4'd12);
        chk("mid_rst_out", 64'(out_b), 64'd0);
        chk("mid_rst_selq", 64'(selq_b), 64'd0);
        chk("mid_rst_cnt", 64'(cnt_b), 64'd0);
        chk("mid_rst_valid", 64'(valid_b), 64'd0);

        // First capture after release uses sel=1 (differs from cleared sel_q) but must not count.
        step(1'b1, 1'b1, 1'b1, 4'd3, 4'd12);
        chk("post_rst_out", 64'(out_a), 64'd12);
        chk("post_rst_cnt", 64'(cnt_a), 64'd0);
        chk("post_rst_cnt_w2", 64'(cnt_b), 64'd0);
        step(1'b1, 1'b1, 1'b0, 4'd3, 4'd12);
        chk("post_rst_sw", 64'(cnt_a), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
